// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multicycle RV32I core: fetch/decode/execute/memory/writeback plus memory handshakes.
// Define ILLEGAL_HALT_EN to halt on illegal opcodes; otherwise they retire as NOPs.
module multicycle_ctrl #(
   parameter int unsigned INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           opcode,
   input  logic                 imem_ready,
   input  logic                 dmem_ready,
   output logic                 imem_req,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic                 ir_we,
   output logic                 aluout_we,
   output logic                 rf_we,
   output logic                 wb_sel,
   output logic                 pc_we,
   output logic [4:0]           ALUControl,
   output logic                 illegal,
   output logic [INSTRET_W-1:0] instret
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   // Class bit positions within cls / ALUControl.
   localparam int unsigned C_R   = 0;
   localparam int unsigned C_I   = 1;
   localparam int unsigned C_LW  = 2;
   localparam int unsigned C_SW  = 3;
   localparam int unsigned C_LUI = 4;

`ifdef ILLEGAL_HALT_EN
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
`else
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;
`endif

   state_t     state;
   state_t     next;
   logic [4:0] cls;
   logic [4:0] dec_cls;
   logic       dec_illegal;

   always_comb begin
      dec_cls = '0;
      case (opcode)
         OP_R:    dec_cls[C_R]   = 1'b1;
         OP_I:    dec_cls[C_I]   = 1'b1;
         OP_LW:   dec_cls[C_LW]  = 1'b1;
         OP_SW:   dec_cls[C_SW]  = 1'b1;
         OP_LUI:  dec_cls[C_LUI] = 1'b1;
         default: dec_cls = '0;
      endcase
      dec_illegal = (dec_cls == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   always_ff @(posedge clk) begin
      if (rst)                  cls <= '0;
      else if (state == DECODE) cls <= dec_cls;
   end

   always_ff @(posedge clk) begin
      if (rst)              instret <= '0;
      else if (state == WB) instret <= instret + INSTRET_W'(1);
   end

`ifdef ILLEGAL_HALT_EN
   logic illegal_q;

   always_ff @(posedge clk) begin
      if (rst)                                 illegal_q <= 1'b0;
      else if (state == DECODE && dec_illegal) illegal_q <= 1'b1;
   end

   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   always_comb begin
      next = state;
      case (state)
         IDLE:   next = FETCH;
         FETCH:  if (imem_ready) next = DECODE;
         DECODE: begin
            if (!dec_illegal) next = EXEC;
`ifdef ILLEGAL_HALT_EN
            else              next = HALT;
`else
            else              next = WB;
`endif
         end
         EXEC:   next = (cls[C_LW] || cls[C_SW]) ? MEM : WB;
         MEM:    if (dmem_ready) next = WB;
         WB:     next = FETCH;
`ifdef ILLEGAL_HALT_EN
         HALT:   next = HALT;
`endif
         default: next = IDLE;
      endcase
   end

   // ir_we follows imem_ready within FETCH so the IR loads in the cycle the data arrives.
   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      aluout_we  = 1'b0;
      rf_we      = 1'b0;
      wb_sel     = 1'b0;
      pc_we      = 1'b0;
      ALUControl = '0;
      case (state)
         FETCH: begin
            imem_req = 1'b1;
            ir_we    = imem_ready;
         end
         EXEC: begin
            ALUControl = cls;
            aluout_we  = 1'b1;
         end
         MEM: begin
            ALUControl = cls;
            dmem_req   = 1'b1;
            dmem_we    = cls[C_SW];
         end
         WB: begin
            ALUControl = cls;
            pc_we      = 1'b1;
            rf_we      = cls[C_R] | cls[C_I] | cls[C_LW] | cls[C_LUI];
            wb_sel     = cls[C_LW];
         end
         default: ;
      endcase
   end

endmodule
